// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings, FSM states
// and the request legality check used at accept time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4,
        ERR   = 3'd5
    } lsu_state_t;

    // True when funct3 names a real access in this direction and the address is naturally aligned.
    function automatic logic access_ok(input logic write, input logic [2:0] funct3, input logic [1:0] lo);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~lo[0];
            F3_W:    ok = (lo == 2'b00);
            F3_BU:   ok = ~write;
            F3_HU:   ok = ~write & ~lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian byte-lane steering: load extract/extend and sub-word store merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = word;
        endcase

        // Sub-word stores keep the untouched lanes of the word just read.
        store_data = word;
        case (funct3)
            F3_B: store_data[{lane, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (lane[1]) store_data[31:16] = wdata[15:0];
                else         store_data[15:0]  = wdata[15:0];
            end
            default: store_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: RV32I loads/stores against a word-wide synchronous RAM,
// with read-modify-write for SB/SH and error reporting for illegal or misaligned requests.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int RD_LAT = 1
) (
    input  logic              clockCPU,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [31:0]       mem_q,
    output logic [2:0]        state_dbg
);

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    lsu_state_t  state;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic [1:0]  cnt;
    logic [31:0] load_word;
    logic [31:0] store_word;

    // Address bits above the RAM size are deliberately dropped: accesses wrap.
    logic addr_high_unused;
    assign addr_high_unused = ^req_addr[31:ADDR_W+2];

    assign state_dbg = state;

    lsu_lane_align u_align (
        .lane       (lane_q),
        .funct3     (funct3_q),
        .word       (mem_q),
        .wdata      (wdata_q),
        .load_data  (load_word),
        .store_data (store_word)
    );

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, so req_valid is ignored while an access is in flight,
    // and done pulses for exactly one cycle per accepted request.
    always_ff @(posedge clockCPU or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'h0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            mem_rden  <= 1'b0;
            mem_wren  <= 1'b0;
            write_q   <= 1'b0;
            funct3_q  <= 3'b000;
            lane_q    <= 2'b00;
            wdata_q   <= 32'h0;
            cnt       <= 2'b00;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        funct3_q  <= req_funct3;
                        lane_q    <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        mem_addr  <= req_addr[ADDR_W+1:2];
                        cnt       <= CNT_INIT;
                        req_ready <= 1'b0;
                        if (!access_ok(req_write, req_funct3, req_addr[1:0])) begin
                            state <= ERR;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (req_write && req_funct3 == F3_W) begin
                            state     <= WRITE;
                            mem_wren  <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= READ;
                            mem_rden <= 1'b1;
                        end
                    end
                end
                READ, WAIT: begin
                    if (cnt == 2'b00) begin
                        mem_rden <= 1'b0;
                        if (write_q) begin
                            state     <= WRITE;
                            mem_wren  <= 1'b1;
                            mem_wdata <= store_word;
                        end else begin
                            state <= RESP;
                            rdata <= load_word;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt   <= cnt - 2'b01;
                        state <= WAIT;
                    end
                end
                WRITE: begin
                    mem_wren <= 1'b0;
                    done     <= 1'b1;
                    state    <= RESP;
                end
                RESP, ERR: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    mem_rden  <= 1'b0;
                    mem_wren  <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage sitting between the multicycle datapath (ALU result/address register, rs2 register) and the word-wide synchronous RAM.
- Executes RV32I LB/LH/LW/LBU/LHU/SB/SH/SW with byte-lane extraction and sign/zero extension.
- Performs read-modify-write for sub-word stores and flags misaligned or illegal accesses.
- The controller FSM issues one request and stalls until `done`.

Parameters:
- ADDR_W, 11: RAM word-address width; RAM holds 2^ADDR_W 32-bit words.
- RD_LAT, 1: RAM read latency in clockCPU cycles, from rden asserted to q valid; legal range 1..3.

Ports:
- clockCPU  in  1  CPU clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request strobe from the controller.
- req_ready  out  1  high when IDLE; a request is accepted on req_valid&&req_ready.
- req_write  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2 register).
- done  out  1  one-cycle pulse: access complete.
- err  out  1  valid with done: misaligned or illegal funct3; no memory side effect.
- rdata  out  32  extended load result; held until the next accepted request.
- mem_addr  out  ADDR_W  RAM word address = addr[ADDR_W+1:2].
- mem_wdata  out  32  RAM write data.
- mem_rden  out  1  RAM read enable.
- mem_wren  out  1  RAM write enable.
- mem_q  in  32  RAM read data.

Behaviour:
- Reset values: all outputs 0 except req_ready=1. State=IDLE; latched address, funct3, wdata and data cleared.
- Reset mid-operation: return to IDLE asynchronously and drop rden/wren at once. An aborted RMW leaves the RAM unchanged, because the write happens only in WRITE.
- Accept (cycle 0): latch req_write, req_funct3, req_addr, req_wdata. req_ready=0 from cycle 1 until return to IDLE. req_valid is ignored when not IDLE.
- Legality check at accept:
  - LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0.
  - Illegal funct3: load 011/110/111, store 011..111.
  - Illegal or misaligned -> state ERR.
- States:
  - IDLE
  - READ: rden=1, wait counter=RD_LAT-1
  - WAIT: counter counts down, rden held
  - WRITE: wren=1
  - RESP: done=1
  - ERR: done=1, err=1
- Transitions:
  - IDLE -> READ for loads and SB/SH.
  - IDLE -> WRITE for SW.
  - IDLE -> ERR for illegal or misaligned requests.
  - READ/WAIT -> when the counter reaches 0: loads go to RESP; SB/SH go to WRITE, with mem_q sampled into the merge register on that edge.
  - WRITE -> RESP; RESP -> IDLE; ERR -> IDLE.
- Cycle counts for RD_LAT=1:
  - loads: done in cycle 2
  - SW: done in cycle 2
  - SB/SH: done in cycle 3
  - error: done in cycle 1
- Load extraction (on the READ/WAIT exit edge, registered into rdata): lane = addr[1:0].
  - LB/LBU: byte lane*8, sign- or zero-extended.
  - LH/LHU: half addr[1]*16, sign- or zero-extended.
  - LW: whole word.
  - rdata is unchanged on stores and errors.
- Store merge: little-endian.
  - SB replaces byte lane with wdata[7:0].
  - SH replaces half addr[1] with wdata[15:0].
  - SW writes wdata unmodified.
- mem_addr and mem_wdata are driven from registers only, glitch-free; mem_addr is stable from READ through WRITE.
- Address bits above ADDR_W+1 are ignored: accesses wrap modulo RAM size, no error.
- rden and wren are never high in the same cycle.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - lsu_state_t enum: IDLE, READ, WAIT, WRITE, RESP, ERR
- Sub-module lsu_lane_align (combinational): load extract/extend and store merge from addr[1:0], funct3, word and wdata. Reused by the bench's reference model.

Test Plan:
- RAM word0=0x8081_7F02. LB addr 0x1 -> rdata=0x0000_007F. LB addr 0x3 -> 0xFFFF_FF80. LBU addr 0x3 -> 0x0000_0080. done in cycle 2, err=0 each time.
- LH addr 0x2 on the same word -> 0xFFFF_8081. LHU addr 0x2 -> 0x0000_8081. LW addr 0x0 -> 0x8081_7F02.
- SB wdata=0xAAAA_AA55 addr 0x6 on word1=0x1122_3344 -> exactly one wren, mem_wdata=0x1155_3344, done in cycle 3. Then SH wdata 0xBEEF at 0x4 -> word1=0x1155_BEEF.
- LW addr 0x2 and SH addr 0x5 -> done=1, err=1 in cycle 1, no rden/wren ever asserted, rdata unchanged.
- Assert reset in the WAIT cycle of an SB at 0x8 -> req_ready=1 and rden=0 immediately, no write ever, word2 unchanged. The next LW completes normally.
- RD_LAT=3: LW -> rden held 3 cycles, done in cycle 4. req_valid pulses while busy are ignored (single access, single done).
